// File: rtl/mem_burst_master.sv
// mem_burst_master: splits client burst requests into single-beat accesses
// on the rd_mem/wr_mem/ready_mem memory port, with a per-beat watchdog.
module mem_burst_master #(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 8,
  parameter int LWIDTH  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              ready_mem
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_STROBE = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // Burst context
  logic                r_write;
  logic [AWIDTH-1:0]   r_addr;
  logic [LWIDTH:0]     r_beats;
  logic [7:0]          r_wd;

  // Registered outputs
  logic                r_rd_mem;
  logic                r_wr_mem;
  logic [AWIDTH-1:0]   r_addr_mem;
  logic [DWIDTH-1:0]   r_mem_wdata;
  logic [DWIDTH-1:0]   r_rdata;
  logic                r_rdata_valid;
  logic                r_done;
  logic                r_err;

  // Combinational handshakes and decoded events
  logic                w_req_ready;
  logic                w_wdata_ready;
  logic                w_accept;
  logic                w_issue;
  logic                w_acked;
  logic                w_last;
  logic                w_timeout;

  assign w_accept  = req_valid & w_req_ready;
  // A write beat can only issue when its data is present; reads only need an idle memory.
  assign w_issue   = (r_state == S_ISSUE) & ready_mem & (~r_write | wdata_valid);
  assign w_acked   = (r_state == S_ACK) & ~ready_mem;
  assign w_last    = (r_beats == (LWIDTH+1)'(1));
  assign w_timeout = (r_state == S_ACK) & ready_mem & (r_wd == 8'(TIMEOUT - 1));

  assign req_ready   = w_req_ready;
  assign wdata_ready = w_wdata_ready;
  assign rd_mem      = r_rd_mem;
  assign wr_mem      = r_wr_mem;
  assign addr_mem    = r_addr_mem;
  assign mem_wdata   = r_mem_wdata;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
        else          w_next = S_IDLE;
      end
      S_ISSUE: begin
        if (w_issue) w_next = S_STROBE;
        else         w_next = S_ISSUE;
      end
      S_STROBE: begin
        w_next = S_ACK;
      end
      S_ACK: begin
        if (w_acked) begin
          if (w_last) w_next = S_IDLE;
          else        w_next = S_ISSUE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_ACK;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Combinational handshake outputs; req_ready is forced low while in reset
  always_comb begin
    w_req_ready   = 1'b0;
    w_wdata_ready = 1'b0;
    if (reset_n && (r_state == S_IDLE)) w_req_ready = 1'b1;
    else                                w_req_ready = 1'b0;
    if ((r_state == S_ISSUE) && r_write && ready_mem) w_wdata_ready = 1'b1;
    else                                              w_wdata_ready = 1'b0;
  end

  // Burst datapath, memory strobes, watchdog and client pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_beats       <= '0;
      r_wd          <= 8'd0;
      r_rd_mem      <= 1'b0;
      r_wr_mem      <= 1'b0;
      r_addr_mem    <= '0;
      r_mem_wdata   <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below
      r_rd_mem      <= 1'b0;
      r_wr_mem      <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;

      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_beats <= {1'b0, req_len} + (LWIDTH+1)'(1);
      end

      if (w_issue) begin
        r_rd_mem   <= ~r_write;
        r_wr_mem   <= r_write;
        r_addr_mem <= r_addr;
        if (r_write) r_mem_wdata <= wdata;
      end

      // Watchdog restarts every time a beat enters ACK
      if (r_state == S_STROBE) r_wd <= 8'd0;

      if (w_acked) begin
        if (!r_write) begin
          r_rdata       <= mem_rdata;
          r_rdata_valid <= 1'b1;
        end
        r_addr  <= r_addr + AWIDTH'(1);
        r_beats <= r_beats - (LWIDTH+1)'(1);
        if (w_last) r_done <= 1'b1;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else if (r_state == S_ACK) begin
        r_wd <= r_wd + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a behavioural single-port memory.
module tb_mem_burst_master;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int LW = 3;

  localparam int K_RS = 0;  // read strobe
  localparam int K_WS = 1;  // write strobe
  localparam int K_RD = 2;  // rdata beat
  localparam int K_DN = 3;  // done
  localparam int K_ER = 4;  // err

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          done;
  logic          err;
  logic          rd_mem;
  logic          wr_mem;
  logic [AW-1:0] addr_mem;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          ready_mem = 1'b1;

  mem_burst_master #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .addr_mem(addr_mem), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ready_mem(ready_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } ev_t;

  typedef struct {
    int d;
    int stall;
  } wb_t;

  ev_t  sb[$];
  wb_t  wq[$];
  int   wr_cyc[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   pcyc = 0;
  int   resume_cyc = -1;
  bit   resume_pend = 1'b0;
  bit   mem_dead = 1'b0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(posedge clk) pcyc <= pcyc + 1;

  // Memory model: accepts a strobe while idle, answers with one cycle of ready low
  always @(posedge clk) begin
    if (!mem_dead && ready_mem && (rd_mem || wr_mem)) begin
      if (wr_mem) mem[addr_mem] <= mem_wdata;
      mem_rdata <= mem[addr_mem];
      ready_mem <= 1'b0;
    end else if (!ready_mem) begin
      ready_mem <= 1'b1;
    end
  end

  // Write data source with optional stall before an entry
  initial begin
    forever begin
      @(negedge clk);
      if (wq.size() > 0 && wq[0].stall > 0) begin
        wdata_valid = 1'b0;
        wq[0].stall = wq[0].stall - 1;
        if (wq[0].stall == 0) resume_pend = 1'b1;
      end else if (wq.size() > 0) begin
        wdata_valid = 1'b1;
        wdata = DW'(wq[0].d);
        if (resume_pend) begin
          resume_cyc = pcyc;
          resume_pend = 1'b0;
        end
        #1;
        if (wdata_ready) void'(wq.pop_front());
      end else begin
        wdata_valid = 1'b0;
      end
    end
  end

  task automatic pop_cmp(input int kind, input int addr, input int data);
    ev_t e;
    chk("sb_empty_on_event", 32'(sb.size() == 0), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      if (e.kind == K_RS || e.kind == K_WS) chk("addr_mem", addr, e.addr);
      if (e.kind == K_WS || e.kind == K_RD) chk("data", data, e.data);
      if (e.cyc >= 0) chk("ev_cycle", pcyc, e.cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_mem || wr_mem) begin
        chk("strobe_excl", 32'(rd_mem & wr_mem), 32'd0);
        if (wr_mem) wr_cyc.push_back(pcyc);
        pop_cmp(wr_mem ? K_WS : K_RS, int'(addr_mem), int'(mem_wdata));
      end
      if (rdata_valid) pop_cmp(K_RD, 0, int'(rdata));
      if (done)        pop_cmp(K_DN, 0, 0);
      if (err)         pop_cmp(K_ER, 0, 0);
    end
  end

  task automatic push(input int kind, input int addr, input int data, input int cyc);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic w, input int a, input int l, output int k);
    int n;
    n = 0;
    k = -1;
    @(negedge clk);
    req_write = w;
    req_addr  = AW'(a);
    req_len   = LW'(l);
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_accept_bound", 32'(req_ready), 32'd1);
    k = pcyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, sb.size(), 32'd0);
  endtask

  task automatic push_read_burst(input int a, input int l);
    for (int i = 0; i <= l; i++) begin
      push(K_RS, (a + i) % (1 << AW), 0, -1);
      push(K_RD, 0, int'(mem[(a + i) % (1 << AW)]), -1);
    end
    push(K_DN, 0, 0, -1);
  endtask

  task automatic single_read5(input string nm);
    int k;
    do_req(1'b0, 5, 0, k);
    push(K_RS, 5, 0, k + 2);
    push(K_RD, 0, 8'hA5, k + 4);
    push(K_DN, 0, 0, k + 4);
    wait_done(nm);
  endtask

  initial begin
    int k;
    int found;
    wb_t wb;
    logic [7:0] wbytes [0:3];
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7 + 3);
    mem[5] = 8'hA5;

    // Reset: outputs and handshakes low while held, req_ready rises on release
    repeat (3) @(negedge clk);
    chk("reset_outs", {rd_mem, wr_mem, addr_mem, mem_wdata, rdata, rdata_valid,
                       done, err, req_ready, wdata_ready}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Single-beat read with exact latency
    single_read5("single_read");

    // Write burst wrapping the top of the address space, then read it back
    wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      wb.d = int'(wbytes[i]); wb.stall = 0;
      wq.push_back(wb);
    end
    do_req(1'b1, 9'h1FE, 3, k);
    for (int i = 0; i < 4; i++) push(K_WS, (9'h1FE + i) % 512, int'(wbytes[i]), -1);
    push(K_DN, 0, 0, -1);
    wait_done("write_wrap");
    do_req(1'b0, 9'h1FE, 3, k);
    for (int i = 0; i < 4; i++) begin
      push(K_RS, (9'h1FE + i) % 512, 0, -1);
      push(K_RD, 0, int'(wbytes[i]), -1);
    end
    push(K_DN, 0, 0, -1);
    wait_done("readback_wrap");

    // Write data stall before the second beat
    wr_cyc.delete();
    wb.d = 8'hAA; wb.stall = 0; wq.push_back(wb);
    wb.d = 8'hBB; wb.stall = 5; wq.push_back(wb);
    wb.d = 8'hCC; wb.stall = 0; wq.push_back(wb);
    do_req(1'b1, 9'h040, 2, k);
    push(K_WS, 9'h040, 8'hAA, -1);
    push(K_WS, 9'h041, 8'hBB, -1);
    push(K_WS, 9'h042, 8'hCC, -1);
    push(K_DN, 0, 0, -1);
    wait_done("write_stall");
    chk("stall_wr_count", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() > 1) chk("stall_resume_cycle", wr_cyc[1], resume_cyc + 1);
    do_req(1'b0, 9'h040, 2, k);
    push(K_RS, 9'h040, 0, -1); push(K_RD, 0, 8'hAA, -1);
    push(K_RS, 9'h041, 0, -1); push(K_RD, 0, 8'hBB, -1);
    push(K_RS, 9'h042, 0, -1); push(K_RD, 0, 8'hCC, -1);
    push(K_DN, 0, 0, -1);
    wait_done("readback_stall");

    // Watchdog: memory never acknowledges
    mem_dead = 1'b1;
    do_req(1'b0, 9'h020, 0, k);
    push(K_RS, 9'h020, 0, k + 2);
    push(K_ER, 0, 0, k + 18);
    wait_done("timeout");
    mem_dead = 1'b0;
    single_read5("read_after_timeout");

    // Reset during the strobe of beat 3 of an 8-beat read
    do_req(1'b0, 9'h010, 7, k);
    push_read_burst(9'h010, 1);
    void'(sb.pop_back());          // burst is cut short: no done
    push(K_RS, 9'h012, 0, -1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (rd_mem && addr_mem == 9'h012) found = 1;
    end
    chk("strobe3_seen", found, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midburst_reset_outs", {rd_mem, wr_mem, addr_mem, mem_wdata, rdata, rdata_valid,
                                done, err, req_ready, wdata_ready}, 32'd0);
    chk("midburst_sb_drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("req_ready_after_midreset", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    single_read5("read_after_midreset");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
